// File: rtl/transaction_control.sv
// Sequences one coin transfer over the shared balance RAM: read both balances, validate, commit.
// Optional TX_LEDGER_COUNT_EN adds a saturating 16-bit count of committed transfers (tx_count).
module transaction_control #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start_transaction,
    input  logic [ADDR_W-1:0] from_id,
    input  logic [ADDR_W-1:0] to_id,
    input  logic [DATA_W-1:0] amount,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
`ifdef TX_LEDGER_COUNT_EN
    output logic [15:0]       tx_count,
`endif
    output logic              busy,
    output logic              finished_transaction,
    output logic [1:0]        status
);

    typedef enum logic [3:0] {
        IDLE, RD_SRC, RD_DST, CAP_DST, CHECK, WR_SRC, WR_DST, DONE, HOLD
    } state_t;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_FUNDS = 2'b01;
    localparam logic [1:0] ST_INVAL = 2'b10;
    localparam logic [1:0] ST_OVF   = 2'b11;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_from, r_to, r_addr, w_addr;
    logic [DATA_W-1:0] r_amt, r_src, r_dst, r_wdata, w_wdata;
    logic [1:0]        r_status, w_chk;
    logic              w_we, w_fin;
    logic [DATA_W:0]   w_sum;

    // Overflow is judged on a one-bit-wider sum so the carry is visible.
    assign w_sum = {1'b0, r_dst} + {1'b0, r_amt};

    always_comb begin
        w_chk = ST_OK;
        if (r_from == r_to || r_amt == '0)
            w_chk = ST_INVAL;
        else if (r_amt > r_src)
            w_chk = ST_FUNDS;
        else if (w_sum[DATA_W])
            w_chk = ST_OVF;
    end

    // Address and write data hold their last value outside the states that drive them.
    always_comb begin
        w_next  = r_state;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_we    = 1'b0;
        w_fin   = 1'b0;
        case (r_state)
            IDLE:    if (start_transaction) w_next = RD_SRC;
            RD_SRC:  begin w_addr = r_from; w_next = RD_DST; end
            RD_DST:  begin w_addr = r_to;   w_next = CAP_DST; end
            CAP_DST: w_next = CHECK;
            CHECK:   w_next = (w_chk == ST_OK) ? WR_SRC : DONE;
            WR_SRC: begin
                w_we    = 1'b1;
                w_addr  = r_from;
                w_wdata = r_src - r_amt;
                w_next  = WR_DST;
            end
            WR_DST: begin
                w_we    = 1'b1;
                w_addr  = r_to;
                w_wdata = w_sum[DATA_W-1:0];
                w_next  = DONE;
            end
            DONE:    begin w_fin = 1'b1; w_next = HOLD; end
            HOLD:    if (!start_transaction) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_from   <= '0;
            r_to     <= '0;
            r_amt    <= '0;
            r_src    <= '0;
            r_dst    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_status <= ST_OK;
        end else begin
            r_state <= w_next;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            if (r_state == IDLE && start_transaction) begin
                r_from   <= from_id;
                r_to     <= to_id;
                r_amt    <= amount;
                r_status <= ST_OK;
            end
            if (r_state == RD_DST)  r_src    <= mem_rdata;
            if (r_state == CAP_DST) r_dst    <= mem_rdata;
            if (r_state == CHECK)   r_status <= w_chk;
        end
    end

`ifdef TX_LEDGER_COUNT_EN
    logic [15:0] r_cnt;
    always_ff @(posedge clock) begin
        if (!resetn)
            r_cnt <= '0;
        else if (r_state == DONE && r_status == ST_OK && r_cnt != 16'hFFFF)
            r_cnt <= r_cnt + 16'd1;
    end
    assign tx_count = r_cnt;
`endif

    assign mem_addr             = w_addr;
    assign mem_wdata            = w_wdata;
    assign mem_we               = w_we;
    assign finished_transaction = w_fin;
    assign busy                 = (r_state != IDLE);
    assign status               = r_status;

endmodule

// File: tb/tb_transaction_control.sv
// Bench for transaction_control: behavioural RAM, table-driven corner cases, random transfers vs a model.
module tb_transaction_control;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start_transaction;
    logic [1:0] from_id, to_id;
    logic [7:0] amount, mem_rdata, mem_wdata;
    logic [1:0] mem_addr, status;
    logic       mem_we, busy, finished_transaction;
`ifdef TX_LEDGER_COUNT_EN
    logic [15:0] tx_count;
`endif

    transaction_control #(.ADDR_W(2), .DATA_W(8)) dut (
        .clock(clock), .resetn(resetn), .start_transaction(start_transaction),
        .from_id(from_id), .to_id(to_id), .amount(amount), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
`ifdef TX_LEDGER_COUNT_EN
        .tx_count(tx_count),
`endif
        .busy(busy), .finished_transaction(finished_transaction), .status(status)
    );

    always #5 clock = ~clock;

    // Balance RAM: one-cycle read latency, write on the edge; preload port used only while idle.
    logic [7:0] ram [4];
    logic       pl_en = 1'b0;
    logic [1:0] pl_addr = '0;
    logic [7:0] pl_data = '0;
    always @(posedge clock) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we)     ram[mem_addr] <= mem_wdata;
        else if (pl_en) ram[pl_addr]  <= pl_data;
    end

    int errors = 0, checks = 0;
    int exp_ram [4];
    int exp_cnt = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic preload(input int a, input int d);
        @(posedge clock); #1;
        pl_en = 1'b1; pl_addr = a[1:0]; pl_data = d[7:0];
        @(posedge clock); #1;
        pl_en = 1'b0;
        exp_ram[a] = d;
    endtask

    function automatic int model_status(input int f, input int t, input int a, input int s, input int d);
        if (f == t || a == 0) return 2;
        if (a > s)            return 1;
        if (d + a > 255)      return 3;
        return 0;
    endfunction

    task automatic check_ram(input string name);
        int bad = 0;
        for (int i = 0; i < 4; i++) if (int'(ram[i]) != exp_ram[i]) bad++;
        check(name, bad, 0);
    endtask

    task automatic run_tx(input int f, input int t, input int a, input int hold,
                          input int exp_st, input string name);
        int src = exp_ram[f], dst = exp_ram[t];
        int fin_cyc = 0, nw = 0;
        bit commit = (exp_st == 0);
        @(posedge clock); #1;
        from_id = f[1:0]; to_id = t[1:0]; amount = a[7:0]; start_transaction = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clock); #1;
            from_id = 2'($urandom); to_id = 2'($urandom); amount = 8'($urandom);
            if (mem_we) begin
                nw++;
                if (cyc == 5) begin
                    check({name, " wr_src_addr"}, mem_addr, f);
                    check({name, " wr_src_data"}, mem_wdata, src - a);
                end else if (cyc == 6) begin
                    check({name, " wr_dst_addr"}, mem_addr, t);
                    check({name, " wr_dst_data"}, mem_wdata, (dst + a) % 256);
                end else check({name, " write_cycle"}, cyc, commit ? 5 : 0);
            end
            if (finished_transaction) begin fin_cyc = cyc; break; end
        end
        check({name, " finish_latency"}, fin_cyc, commit ? 7 : 5);
        check({name, " status"}, status, exp_st);
        check({name, " writes"}, nw, commit ? 2 : 0);
        if (commit) begin
            exp_ram[f] = src - a;
            exp_ram[t] = dst + a;
            if (exp_cnt < 65535) exp_cnt++;
        end
        // First cycle after the pulse is HOLD; keep start high for extra cycles.
        @(posedge clock); #1;
        check({name, " hold_busy"}, {busy, finished_transaction}, 2'b10);
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            check({name, " hold_no_retrigger"}, {busy, finished_transaction, mem_we}, 3'b100);
        end
        start_transaction = 1'b0;
        @(posedge clock); #1;
        check({name, " idle_after_drop"}, busy, 0);
        check({name, " status_held"}, status, exp_st);
        check_ram({name, " ram"});
`ifdef TX_LEDGER_COUNT_EN
        check({name, " tx_count"}, tx_count, exp_cnt);
`endif
    endtask

    typedef struct {
        int f, t, a, src, dst, hold, st;
    } vec_t;

    initial begin
        vec_t vecs [9];
        int nfail_wr;
        vecs[0] = '{f:0, t:1, a:20,  src:50,  dst:10,  hold:5, st:0};
        vecs[1] = '{f:2, t:3, a:6,   src:5,   dst:0,   hold:0, st:1};
        vecs[2] = '{f:1, t:1, a:4,   src:10,  dst:10,  hold:1, st:2};
        vecs[3] = '{f:0, t:2, a:0,   src:40,  dst:7,   hold:0, st:2};
        vecs[4] = '{f:0, t:3, a:10,  src:100, dst:250, hold:2, st:3};
        vecs[5] = '{f:3, t:2, a:255, src:255, dst:0,   hold:0, st:0};
        vecs[6] = '{f:0, t:1, a:55,  src:60,  dst:200, hold:0, st:0};
        vecs[7] = '{f:0, t:1, a:56,  src:60,  dst:200, hold:0, st:3};
        vecs[8] = '{f:0, t:1, a:61,  src:60,  dst:250, hold:0, st:1};

        for (int i = 0; i < 4; i++) begin ram[i] = 8'd0; exp_ram[i] = 0; end
        resetn = 1'b0; start_transaction = 1'b0; from_id = '0; to_id = '0; amount = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", {busy, finished_transaction, mem_we, status, mem_addr, mem_wdata},
              0);
`ifdef TX_LEDGER_COUNT_EN
        check("reset_tx_count", tx_count, 0);
`endif
        resetn = 1'b1;

        for (int i = 0; i < 9; i++) begin
            preload(vecs[i].f, vecs[i].src);
            if (vecs[i].t != vecs[i].f) preload(vecs[i].t, vecs[i].dst);
            run_tx(vecs[i].f, vecs[i].t, vecs[i].a, vecs[i].hold, vecs[i].st,
                   $sformatf("vec%0d", i));
        end

        // Reset landing in CAP_DST: back to IDLE on the next edge with no write.
        preload(0, 80); preload(1, 5);
        @(posedge clock); #1;
        from_id = 2'd0; to_id = 2'd1; amount = 8'd30; start_transaction = 1'b1;
        nfail_wr = 0;
        repeat (3) begin @(posedge clock); #1; if (mem_we) nfail_wr++; end
        resetn = 1'b0; start_transaction = 1'b0;
        @(posedge clock); #1;
        check("rst_mid busy/status/we", {busy, status, mem_we}, 0);
        check("rst_mid no_write_before", nfail_wr, 0);
        resetn = 1'b1;
        exp_cnt = 0;
        repeat (3) begin @(posedge clock); #1; if (mem_we) nfail_wr++; end
        check("rst_mid idle_no_write", {busy, 4'(nfail_wr)}, 0);
        check_ram("rst_mid ram");

        for (int n = 0; n < 40; n++) begin
            int f, t, a, st;
            for (int i = 0; i < 4; i++) preload(i, $urandom_range(0, 255));
            f = $urandom_range(0, 3);
            t = ($urandom_range(0, 4) == 0) ? f : $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0:       a = 0;
                1:       a = $urandom_range(0, 40);
                default: a = $urandom_range(0, 255);
            endcase
            st = model_status(f, t, a, exp_ram[f], exp_ram[t]);
            run_tx(f, t, a, $urandom_range(0, 3), st, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/transaction_control.md
Name: transaction_control

Overview:
- Sequences the shared balance RAM for one coin transfer: reads both balances, validates, then commits debit and credit.
- Sits between main_control and the balance memory.
- Consumes main_control's start_transaction level and returns a finished_transaction pulse plus a result code.
- Owns the RAM port only while busy; mem_we is 0 at all other times.

Parameters:
- ADDR_W, 2, account-id width (4 accounts).
- DATA_W, 8, balance and amount width, unsigned.

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous active-low reset
- start_transaction  in  1  level request from main_control, held until finished_transaction
- from_id  in  ADDR_W  sender account, sampled on acceptance
- to_id  in  ADDR_W  receiver account, sampled on acceptance
- amount  in  DATA_W  transfer amount, sampled on acceptance
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after the address is presented
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_we  out  1  RAM write enable
- busy  out  1  high in every state except IDLE
- finished_transaction  out  1  one-cycle done pulse
- status  out  2  result, held until the next acceptance: 00 ok, 01 insufficient funds, 10 invalid (from_id==to_id or amount==0), 11 receiver overflow

Behaviour:
- Reset is synchronous, active-low, clock clock.
- Values at reset: state IDLE; mem_we 0, mem_addr 0, mem_wdata 0, busy 0, finished_transaction 0, status 00; internal latches cleared.
- States, in order:
  - IDLE: if start_transaction=1, latch from_id, to_id, amount; go to RD_SRC.
  - RD_SRC: mem_addr=from; go to RD_DST.
  - RD_DST: mem_addr=to; capture mem_rdata as src_bal; go to CAP_DST.
  - CAP_DST: capture mem_rdata as dst_bal; go to CHECK.
  - CHECK: compute status with priority invalid > insufficient (amount > src_bal) > overflow (dst_bal + amount > 2^DATA_W-1, evaluated in a DATA_W+1-bit sum). If status is 00, go to WR_SRC; otherwise go to DONE.
  - WR_SRC: mem_we=1, mem_addr=from, mem_wdata=src_bal-amount; go to WR_DST.
  - WR_DST: mem_we=1, mem_addr=to, mem_wdata=dst_bal+amount (low DATA_W bits); go to DONE.
  - DONE: finished_transaction=1 for exactly this cycle; status is valid. Go to HOLD.
  - HOLD: stay while start_transaction=1; go to IDLE when it is 0. This prevents re-triggering on main_control's still-high level.
- Latency, counting from the IDLE cycle with start high as T:
  - Commit: writes at T+5 and T+6, finished pulse at T+7.
  - Reject: finished pulse at T+5; no write occurs.
- Rejects are atomic: no RAM write on any non-00 status. Total coins are conserved on commit.
- Inputs from_id, to_id, amount may change after acceptance without effect.
- start_transaction dropping mid-sequence is ignored; the sequence completes, then HOLD exits on the next cycle.
- mem_addr holds its last value when not driven by a state. mem_we=1 only in WR_SRC and WR_DST.
- Reset mid-operation returns to IDLE on the next edge with mem_we=0.
  - A reset landing between WR_SRC and WR_DST leaves the sender debited and the receiver not credited.
  - main_control never asserts resetn during Transaction.

Optional Feature:
- Macro: TX_LEDGER_COUNT_EN.
- Defined:
  - Adds output tx_count, 16 bits, reset to 0.
  - Increments by 1 in the DONE cycle when status=00.
  - Saturates at 16'hFFFF.
  - Rejects never increment it.
- Undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset, then RAM[0]=50, RAM[1]=10; start with from=0, to=1, amount=20 → writes RAM[0]=30 at T+5, RAM[1]=30 at T+6; finished at T+7; status=00.
- RAM[2]=5; from=2, to=3, amount=6 → status=01 at T+5; mem_we never 1; RAM unchanged.
- from=1, to=1, amount=4, and separately amount=0 → status=10 at T+5; no writes.
- RAM[0]=100, RAM[3]=250; from=0, to=3, amount=10 → status=11; no writes (260 exceeds 255).
- Hold start_transaction high for 5 cycles after finished → exactly one transaction and one pulse. Drop start for 1 cycle, raise it again → second transaction accepted.
- Assert resetn=0 during CAP_DST → next cycle state IDLE, busy=0, status=00, no write. With TX_LEDGER_COUNT_EN: 3 commits and 1 reject → tx_count=3.
